sprite_read_arbiter: RTL and testbench
======================================

Name: sprite_read_arbiter

Overview:
- Shares one single-port-read sprite RAM among N_REQ draw units, e.g. four ghost renderers contending for one 26x26 sprite RAM.
- Sprite RAM: 24-bit RGB, 10-bit address, registered read with 1-cycle latency.
- Each requester presents an (x,y) texel coordinate. The block grants round-robin, converts the coordinate to a linear address, issues the read, and returns tagged data.
- Sits between the per-sprite draw logic and the sprite RAM instance in the frame-drawing path.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- SPR_W, 26, sprite width in pixels.
- SPR_H, 26, sprite height in pixels.
- ADDR_W, 10, sprite RAM address width; must satisfy SPR_W*SPR_H <= 2**ADDR_W.
- DATA_W, 24, texel width (RGB888).
- ID_W, 2, requester tag width, = clog2(N_REQ).

Ports:
- Clk  in  1  system clock; all logic on posedge.
- Reset  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-requester read request; level, held until granted.
- req_x  in  N_REQ*5  packed x coordinate per requester; slot i at [5i+4:5i].
- req_y  in  N_REQ*5  packed y coordinate per requester, same packing.
- gnt  out  N_REQ  one-hot grant, combinational from req and priority pointer.
- mem_read_address  out  ADDR_W  registered address to sprite RAM read_address.
- mem_data_Out  in  DATA_W  sprite RAM data_Out (registered inside the RAM).
- rd_valid  out  1  returned texel valid.
- rd_id  out  ID_W  requester index owning rd_data.
- rd_data  out  DATA_W  returned texel.
- rd_oob  out  1  coordinate was out of range; rd_data is forced to 0.

Behaviour:
- Reset values (cycle after Reset sampled high):
  - mem_read_address=0, rd_valid=0, rd_id=0, rd_data=0, rd_oob=0.
  - Priority pointer=0; both pipeline valid bits cleared.
  - gnt=0 while Reset is high.
- Arbitration, cycle T:
  - Scan req starting at the pointer, wrapping modulo N_REQ. The first asserted index k gets gnt[k]=1.
  - At most one grant per cycle; zero grants if req==0.
  - A requester drops or changes req only after the cycle in which it saw gnt high.
- Pointer update: on a grant to k, pointer <= (k+1) mod N_REQ. With no grant the pointer holds.
- Address calculation (combinational in T):
  - addr = y*SPR_W + x, computed at ADDR_W+1 bits, then truncated to ADDR_W.
  - oob = (x >= SPR_W) or (y >= SPR_H).
  - On oob, addr is replaced with 0 so no out-of-range RAM access is issued.
- Pipeline stage 1, edge ending T:
  - Register mem_read_address, s1_valid=1, s1_id=k, s1_oob.
  - Without a grant: s1_valid=0 and mem_read_address holds its previous value.
- RAM stage, edge ending T+1: the RAM registers data_Out. s2_valid, s2_id and s2_oob shift from s1.
- Output, cycle T+2:
  - rd_valid=s2_valid, rd_id=s2_id, rd_oob=s2_oob.
  - rd_data = s2_oob ? 0 : mem_data_Out.
  - rd_* fields are zero when rd_valid=0.
- Latency and throughput:
  - Fixed latency of 2 cycles from grant to rd_valid.
  - Full throughput: one texel per cycle, back-to-back grants to different or the same requester.
- Fairness: with all requests held continuously, grants cycle 0,1,2,3,0,... Every requester waits at most N_REQ-1 cycles.
- Single requester: the same index is granted every cycle while its req stays high.
- Reset mid-operation:
  - In-flight reads are discarded: no rd_valid for them after Reset.
  - The pointer returns to 0.
  - Requesters must reissue.
- There is no backpressure on the return path. Consumers must accept rd_valid in the cycle it is asserted.

Decomposition:
- Package sprite_pkg holds:
  - SPR_W, SPR_H, ADDR_W, DATA_W constants.
  - typedef texel_t (logic [23:0]).
  - typedef spr_addr_t (logic [9:0]).
  - typedef coord_t (logic [4:0]).
  - function spr_linear_addr(x,y).
- One sub-module, rr_arbiter: parameter N; ports req, ptr-update enable, gnt, gnt_idx; owns the rotating priority pointer.
- Address calculation and the two-stage tag pipeline stay in the top-level module.

Test Plan:
- Reset, then req=4'b0001 with (x,y)=(3,2) for 1 cycle:
  - gnt=0001 in that cycle.
  - mem_read_address=55 on the next cycle.
  - Two cycles after the grant: rd_valid=1, rd_id=0, rd_data=mem[55].
- req=4'b1111 held for 8 cycles, all at (0,0):
  - Grant order 0,1,2,3,0,1,2,3.
  - rd_valid continuous from the 3rd cycle, rd_id following the same order.
- req[2] at (25,25) and req[1] at (26,0) granted in consecutive cycles:
  - First return has address 675 and rd_data=mem[675], rd_oob=0.
  - Second return has rd_oob=1, rd_data=0, and issued address 0.
- After a grant to 3, req=4'b1001:
  - Next grant goes to 0 (wrap).
  - Then 3.
- Continuous req=4'b0100: gnt[2] every cycle, one texel per cycle, pointer stays at 3.
- Issue two grants, assert Reset for 1 cycle on the following edge:
  - No rd_valid for either in-flight read.
  - Pointer is 0.
  - The first grant after reset goes to the lowest requesting index.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared sprite-RAM constants, texel/address/coordinate types and the
// coordinate-to-linear-address helper used by the sprite read path.
package sprite_pkg;

    localparam int SPR_W   = 26;
    localparam int SPR_H   = 26;
    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 24;
    localparam int COORD_W = 5;

    typedef logic [23:0] texel_t;
    typedef logic [9:0]  spr_addr_t;
    typedef logic [4:0]  coord_t;

    // Row-major address y*w + x, formed one bit wider than the RAM address
    // and then truncated to the RAM address width.
    function automatic spr_addr_t spr_linear_addr(input coord_t x, input coord_t y,
                                                  input int unsigned w = SPR_W);
        logic [ADDR_W:0] wide;
        wide = (ADDR_W+1)'(y) * (ADDR_W+1)'(w) + (ADDR_W+1)'(x);
        return wide[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/sprite_read_arbiter_if.sv
// Requester-side bus of the sprite read arbiter: texel requests in, grants
// and tagged texel returns out.
//
// Handshake: req[i] is a level. A requester raises it with its (x,y) slot
// valid and holds both unchanged until the cycle in which it sees gnt[i]
// high; that cycle is the transfer. The return comes exactly two cycles
// later as a single-cycle rd_valid pulse tagged with rd_id. There is no
// ready on the return path: the consumer must take it in that cycle.
interface sprite_read_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int ID_W   = 2,
    parameter int DATA_W = 24
);
    logic [N_REQ-1:0]   req;
    logic [N_REQ*5-1:0] req_x;
    logic [N_REQ*5-1:0] req_y;
    logic [N_REQ-1:0]   gnt;
    logic               rd_valid;
    logic [ID_W-1:0]    rd_id;
    logic [DATA_W-1:0]  rd_data;
    logic               rd_oob;

    modport master (
        output req, req_x, req_y,
        input  gnt, rd_valid, rd_id, rd_data, rd_oob
    );

    modport slave (
        input  req, req_x, req_y,
        output gnt, rd_valid, rd_id, rd_data, rd_oob
    );
endinterface

// File: rtl/sprite_read_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the
// rotating priority pointer; the pointer moves past the winner on update.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic [N-1:0]  req,
    input  logic          ptr_en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic [IW-1:0] ptr
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] scan_idx;
    logic          found;
    int            j;

    assign ptr = ptr_q;

    // Wrapping priority scan from the pointer; no grant while in reset.
    always_comb begin
        gnt      = '0;
        gnt_idx  = '0;
        found    = 1'b0;
        scan_idx = '0;
        j        = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr_q) + i;
            if (j >= N) begin
                j = j - N;
            end
            scan_idx = IW'(j);
            if (!found && !Reset && req[scan_idx]) begin
                found         = 1'b1;
                gnt[scan_idx] = 1'b1;
                gnt_idx       = scan_idx;
            end
        end
    end

    // Pointer moves to one past the winner; holds when nothing is granted.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ptr_q <= '0;
        end else if (ptr_en && found) begin
            if (gnt_idx == IW'(N - 1)) begin
                ptr_q <= '0;
            end else begin
                ptr_q <= gnt_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sprite_read_arbiter.sv
// Shares one registered-read sprite RAM among N_REQ draw units: arbitrates,
// converts (x,y) to a linear address, and returns tagged texels two cycles
// after the grant. Out-of-range coordinates read address 0 and return 0.
module sprite_read_arbiter #(
    parameter int N_REQ  = 4,
    parameter int SPR_W  = sprite_pkg::SPR_W,
    parameter int SPR_H  = sprite_pkg::SPR_H,
    parameter int ADDR_W = sprite_pkg::ADDR_W,
    parameter int DATA_W = sprite_pkg::DATA_W,
    parameter int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    Clk,
    input  logic                    Reset,
    sprite_read_arbiter_if.slave    bus,
    output logic [ADDR_W-1:0]       mem_read_address,
    input  logic [DATA_W-1:0]       mem_data_Out,
    output logic [ID_W-1:0]         dbg_ptr
);
    import sprite_pkg::*;

    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_idx;
    logic             any_gnt;

    coord_t           sel_x;
    coord_t           sel_y;
    int               sel_base;
    logic             oob;
    logic [ADDR_W-1:0] addr;

    logic             s1_valid;
    logic [ID_W-1:0]  s1_id;
    logic             s1_oob;
    logic             s2_valid;
    logic [ID_W-1:0]  s2_id;
    logic             s2_oob;

    rr_arbiter #(
        .N  (N_REQ),
        .IW (ID_W)
    ) u_arb (
        .Clk     (Clk),
        .Reset   (Reset),
        .req     (bus.req),
        .ptr_en  (any_gnt),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .ptr     (dbg_ptr)
    );

    assign any_gnt = |gnt;
    assign bus.gnt = gnt;

    // Pick the winner's coordinate and map it to a RAM address; out-of-range
    // coordinates are steered to address 0.
    always_comb begin
        sel_base = 5 * int'(gnt_idx);
        sel_x    = bus.req_x[sel_base +: 5];
        sel_y    = bus.req_y[sel_base +: 5];
        oob      = (int'(sel_x) >= SPR_W) || (int'(sel_y) >= SPR_H);
        addr     = oob ? '0 : ADDR_W'(spr_linear_addr(sel_x, sel_y, SPR_W));
    end

    // Stage 1: issue the RAM address and launch the tag; the address holds
    // when nothing is granted.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            mem_read_address <= '0;
            s1_valid         <= 1'b0;
            s1_id            <= '0;
            s1_oob           <= 1'b0;
        end else begin
            s1_valid <= any_gnt;
            if (any_gnt) begin
                mem_read_address <= addr;
                s1_id            <= gnt_idx;
                s1_oob           <= oob;
            end
        end
    end

    // Stage 2: tag travels alongside the RAM's internal output register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            s2_valid <= 1'b0;
            s2_id    <= '0;
            s2_oob   <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            s2_id    <= s1_id;
            s2_oob   <= s1_oob;
        end
    end

    // Return path: fields are zero unless valid; out-of-range returns zero data.
    always_comb begin
        bus.rd_valid = s2_valid;
        bus.rd_id    = s2_valid ? s2_id : '0;
        bus.rd_oob   = s2_valid & s2_oob;
        bus.rd_data  = (s2_valid && !s2_oob) ? mem_data_Out : '0;
    end

endmodule

// File: tb/tb_sprite_read_arbiter.sv
// Directed bench for sprite_read_arbiter with a registered-read RAM model.
module tb_sprite_read_arbiter;

    localparam int N_REQ  = 4;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 24;
    localparam int ID_W   = 2;

    logic              Clk;
    logic              Reset;
    logic [ADDR_W-1:0] mem_read_address;
    logic [DATA_W-1:0] mem_data_Out;
    logic [ID_W-1:0]   dbg_ptr;

    int n_checks;
    int n_pass;

    sprite_read_arbiter_if #(.N_REQ(N_REQ), .ID_W(ID_W), .DATA_W(DATA_W)) bus ();

    sprite_read_arbiter #(
        .N_REQ  (N_REQ),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .ID_W   (ID_W)
    ) dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .bus              (bus),
        .mem_read_address (mem_read_address),
        .mem_data_Out     (mem_data_Out),
        .dbg_ptr          (dbg_ptr)
    );

    // Clock and RAM model
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [DATA_W-1:0] tex(input int a);
        return 24'hC00000 ^ 24'(a * 4099);
    endfunction

    always @(posedge Clk) mem_data_Out <= tex(int'(mem_read_address));

    // Driver tasks
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic mid();
        #3;
    endtask

    task automatic set_xy(input int i, input int x, input int y);
        bus.req_x[5*i +: 5] = 5'(x);
        bus.req_y[5*i +: 5] = 5'(y);
    endtask

    task automatic apply_reset();
        tick();
        Reset   = 1'b1;
        bus.req = '0;
        tick();
        Reset   = 1'b0;
    endtask

    // Scoreboard check
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        Reset     = 1'b1;
        bus.req   = '0;
        bus.req_x = '0;
        bus.req_y = '0;

        // Grant is suppressed while Reset is high
        tick();
        bus.req = 4'b1111;
        mid();
        check("gnt_in_reset", 32'(bus.gnt), 32'h0);
        tick();
        Reset   = 1'b0;
        bus.req = '0;
        mid();
        check("rst_rd_valid", 32'(bus.rd_valid), 32'h0);
        check("rst_rd_id", 32'(bus.rd_id), 32'h0);
        check("rst_rd_data", 32'(bus.rd_data), 32'h0);
        check("rst_rd_oob", 32'(bus.rd_oob), 32'h0);
        check("rst_addr", 32'(mem_read_address), 32'h0);
        check("rst_ptr", 32'(dbg_ptr), 32'h0);

        // Single read at (3,2) -> address 55
        tick();
        bus.req = 4'b0001;
        set_xy(0, 3, 2);
        mid();
        check("t1_gnt", 32'(bus.gnt), 32'h1);
        tick();
        bus.req = '0;
        mid();
        check("t1_addr", 32'(mem_read_address), 32'd55);
        check("t1_valid_early", 32'(bus.rd_valid), 32'h0);
        check("t1_ptr", 32'(dbg_ptr), 32'h1);
        tick();
        mid();
        check("t1_valid", 32'(bus.rd_valid), 32'h1);
        check("t1_id", 32'(bus.rd_id), 32'h0);
        check("t1_data", 32'(bus.rd_data), 32'(tex(55)));
        check("t1_oob", 32'(bus.rd_oob), 32'h0);

        // All four requesting at (0,0): rotation 0,1,2,3,...
        apply_reset();
        for (int i = 0; i < N_REQ; i++) set_xy(i, 0, 0);
        for (int c = 0; c < 10; c++) begin
            tick();
            bus.req = (c < 8) ? 4'b1111 : 4'b0000;
            mid();
            if (c < 8) check($sformatf("rr_gnt%0d", c), 32'(bus.gnt), 32'(1 << (c % 4)));
            if (c >= 2) begin
                check($sformatf("rr_valid%0d", c), 32'(bus.rd_valid), 32'h1);
                check($sformatf("rr_id%0d", c), 32'(bus.rd_id), 32'((c - 2) % 4));
                check($sformatf("rr_data%0d", c), 32'(bus.rd_data), 32'(tex(0)));
            end
        end
        tick();
        mid();
        check("rr_drain_valid", 32'(bus.rd_valid), 32'h0);
        check("rr_drain_data", 32'(bus.rd_data), 32'h0);

        // Corner texel (25,25) then out-of-range x=26
        apply_reset();
        tick();
        bus.req = 4'b0100;
        set_xy(2, 25, 25);
        set_xy(1, 26, 0);
        mid();
        check("edge_gnt2", 32'(bus.gnt), 32'h4);
        tick();
        bus.req = 4'b0010;
        mid();
        check("edge_gnt1", 32'(bus.gnt), 32'h2);
        check("edge_addr675", 32'(mem_read_address), 32'd675);
        tick();
        bus.req = '0;
        mid();
        check("edge_addr_oob", 32'(mem_read_address), 32'd0);
        check("edge_valid_a", 32'(bus.rd_valid), 32'h1);
        check("edge_id_a", 32'(bus.rd_id), 32'd2);
        check("edge_data_a", 32'(bus.rd_data), 32'(tex(675)));
        check("edge_oob_a", 32'(bus.rd_oob), 32'h0);
        tick();
        mid();
        check("edge_valid_b", 32'(bus.rd_valid), 32'h1);
        check("edge_id_b", 32'(bus.rd_id), 32'd1);
        check("edge_oob_b", 32'(bus.rd_oob), 32'h1);
        check("edge_data_b", 32'(bus.rd_data), 32'h0);

        // Wrap: grant 3, then 1001 goes 0 then 3
        apply_reset();
        set_xy(0, 1, 0);
        set_xy(3, 2, 0);
        tick();
        bus.req = 4'b1000;
        mid();
        check("wrap_gnt3", 32'(bus.gnt), 32'h8);
        tick();
        bus.req = 4'b1001;
        mid();
        check("wrap_ptr", 32'(dbg_ptr), 32'h0);
        check("wrap_gnt0", 32'(bus.gnt), 32'h1);
        tick();
        bus.req = 4'b1000;
        mid();
        check("wrap_gnt3b", 32'(bus.gnt), 32'h8);

        // Single requester held: granted every cycle, pointer parks at 3
        apply_reset();
        set_xy(2, 1, 1);
        for (int c = 0; c < 5; c++) begin
            tick();
            bus.req = 4'b0100;
            mid();
            check($sformatf("solo_gnt%0d", c), 32'(bus.gnt), 32'h4);
            if (c >= 1) check($sformatf("solo_ptr%0d", c), 32'(dbg_ptr), 32'd3);
            if (c >= 2) begin
                check($sformatf("solo_id%0d", c), 32'(bus.rd_id), 32'd2);
                check($sformatf("solo_data%0d", c), 32'(bus.rd_data), 32'(tex(27)));
            end
        end

        // Reset with two reads in flight
        apply_reset();
        set_xy(0, 4, 0);
        set_xy(1, 5, 0);
        set_xy(2, 6, 0);
        tick();
        bus.req = 4'b0001;
        mid();
        check("mid_gnt_a", 32'(bus.gnt), 32'h1);
        tick();
        bus.req = 4'b0010;
        mid();
        check("mid_gnt_b", 32'(bus.gnt), 32'h2);
        tick();
        bus.req = '0;
        Reset   = 1'b1;
        tick();
        Reset   = 1'b0;
        mid();
        check("mid_valid0", 32'(bus.rd_valid), 32'h0);
        check("mid_ptr", 32'(dbg_ptr), 32'h0);
        check("mid_addr", 32'(mem_read_address), 32'h0);
        bus.req = 4'b0110;
        #1;
        check("mid_first_gnt", 32'(bus.gnt), 32'h2);
        tick();
        bus.req = '0;
        mid();
        check("mid_valid1", 32'(bus.rd_valid), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
